ram_mfc_ctrl: RTL
=================

RAM_MFC_CTRL -- requirements
Module: ram_mfc_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 256, byte capacity; power of two, >= 8.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request capture to access commit; >= 1.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH_BYTES), byte address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mov  input  1  memory request strobe; held high until mfc seen.
REQ-007 SHALL have port rw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port word_sel  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port addr  input  ADDR_W  byte address of access.
REQ-010 SHALL have port din  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-011 SHALL have port dout  output  32  read data, zero-extended, right-justified.
REQ-012 SHALL have port mfc  output  1  memory function complete.
REQ-013 SHALL have port err  output  1  request rejected (misaligned or illegal size); valid while mfc=1.
REQ-014 SHALL have ports ld_en (input, 1), ld_addr (input, ADDR_W-2), ld_data (input, 32): backdoor word preload.

Function
REQ-015 SHALL store big-endian: word at byte address A = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}.
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-017 IDLE, mov=1: SHALL latch addr, rw, word_sel and din; go BUSY with counter=LATENCY-1. If the request is illegal, SHALL go DONE with err=1 instead.
REQ-018 Illegal: word_sel=11; halfword with addr[0]=1; word with addr[1:0]!=00. Illegal requests SHALL leave memory and dout unchanged.
REQ-019 BUSY: SHALL decrement the counter each cycle. In the cycle the counter is 0, SHALL commit the access (write bytes, or load dout) and go DONE.
REQ-020 Latency: mfc SHALL rise exactly LATENCY+1 cycles after the edge sampling mov=1 in IDLE; for illegal requests, 1 cycle.
REQ-021 DONE: mfc=1 and dout stable. SHALL stay in DONE while mov=1; on mov=0 SHALL go IDLE and drop mfc on that edge.
REQ-022 Write SHALL modify only addressed bytes: byte -> Mem[A]=din[7:0]; halfword -> Mem[A]=din[15:8], Mem[A+1]=din[7:0].
REQ-023 Read byte -> dout={24'b0,Mem[A]}; halfword -> {16'b0,Mem[A],Mem[A+1]}; word per REQ-015.
REQ-024 Changes to mov/addr/din while BUSY or DONE SHALL be ignored (latched values used).
REQ-025 ld_en SHALL write ld_data to word ld_addr (big-endian) only in IDLE with mov=0. Otherwise it SHALL be ignored.
REQ-026 ld_en=1 and mov=1 in the same IDLE cycle: mov SHALL win; the preload is dropped.
REQ-027 err SHALL be 0 whenever mfc=0.

Reset
REQ-028 clr=1 at a clock edge SHALL force: state=IDLE, mfc=0, err=0, dout=0, counter=0.
REQ-029 Memory contents SHALL NOT be cleared by clr.
REQ-030 clr during BUSY before commit SHALL abandon the access with no memory write.
REQ-031 clr SHALL take priority over mov and ld_en.

Structure
REQ-032 Shared package ram_mfc_pkg SHALL hold the word_sel encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-033 Byte storage SHALL be a sub-module ram_mfc_array with 4 byte-lane write enables and a 32-bit aligned read.
REQ-034 The controller SHALL contain the FSM, latency counter, alignment check and lane steering.

Verification
REQ-035 Preload word 0x0 = 0xE5910004; word read at addr 0 with LATENCY=2 -> dout=0xE5910004, mfc high on 3rd edge after mov.
REQ-036 Preload 0xA611FF00 at addr 8; byte read addr 9 -> 0x00000011; halfword read addr 10 -> 0x0000FF00.
REQ-037 Byte write 0x5A to addr 10 over 0xA611FF00; word read addr 8 -> 0xA6115A00.
REQ-038 Halfword read addr 3 -> err=1, mfc after 1 cycle, dout unchanged; word_sel=11 -> err=1.
REQ-039 Word write 0xDEADBEEF to addr 4 with clr pulsed while BUSY -> mfc stays 0; later read of addr 4 returns the prior value.
REQ-040 Hold mov=1 for 5 cycles after mfc -> mfc stays high; mfc drops on the edge after mov=0. Repeat with LATENCY=1 and LATENCY=4.

Source files
------------

// File: rtl/ram_mfc_pkg.sv
// Shared encodings for the byte-addressable handshake RAM: access sizes,
// controller states and the alignment rule.
package ram_mfc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Halfwords must sit on even bytes, words on 4-byte boundaries.
    function automatic logic isLegal(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_mfc_array.sv
// Purpose: word-organised byte storage, lane i holds byte offset i (big-endian).
// Latency: writes land on the clock edge, the aligned read is combinational.
// Backpressure: none; every enabled lane is written unconditionally.
module ram_mfc_array #(
    parameter int DEPTH_BYTES = 256,
    parameter int WADDR_W     = $clog2(DEPTH_BYTES) - 2
) (
    input  logic               clk,
    input  logic [3:0]         wrEn,
    input  logic [WADDR_W-1:0] wordAddr,
    input  logic [31:0]        wrData,
    output logic [31:0]        rdData
);

    localparam int WORDS = DEPTH_BYTES / 4;

    logic [7:0] mem [WORDS][4];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrEn[i]) begin
                mem[wordAddr][i] <= wrData[31-8*i -: 8];
            end
        end
    end

    assign rdData = {mem[wordAddr][0], mem[wordAddr][1], mem[wordAddr][2], mem[wordAddr][3]};

endmodule

// File: rtl/ram_mfc_ctrl.sv
// Purpose: mov/mfc handshake controller over a byte-addressable big-endian RAM.
// Latency: mfc on the (LATENCY+1)th edge counting the one that samples mov; illegal requests on that first edge.
// Backpressure: requester holds mov until mfc; DONE is held until mov drops.
module ram_mfc_ctrl
    import ram_mfc_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mov,
    input  logic              rw,
    input  logic [1:0]        word_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              mfc,
    output logic              err,
    input  logic              ld_en,
    input  logic [ADDR_W-3:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] latAddr;
    logic              latRw;
    logic [1:0]        latSz;
    logic [31:0]       latDin;

    logic [3:0]        arrWrEn;
    logic [ADDR_W-3:0] arrWordAddr;
    logic [31:0]       arrWrData;
    logic [31:0]       rdData;

    logic [3:0]        laneEn;
    logic [31:0]       laneData;
    logic [31:0]       rdValue;
    logic              commit;

    assign commit = (state == BUSY) && (cnt == '0);

    ram_mfc_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .WADDR_W     (ADDR_W - 2)
    ) u_array (
        .clk      (clk),
        .wrEn     (arrWrEn),
        .wordAddr (arrWordAddr),
        .wrData   (arrWrData),
        .rdData   (rdData)
    );

    // Replicate the right-justified write data so every candidate lane sees it.
    always_comb begin
        laneEn   = 4'hF;
        laneData = latDin;
        case (latSz)
            SZ_BYTE: begin
                laneEn   = 4'b0001 << latAddr[1:0];
                laneData = {4{latDin[7:0]}};
            end
            SZ_HALF: begin
                laneEn   = latAddr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{latDin[15:0]}};
            end
            default: begin
                laneEn   = 4'hF;
                laneData = latDin;
            end
        endcase
    end

    always_comb begin
        rdValue = rdData;
        case (latSz)
            SZ_BYTE: begin
                case (latAddr[1:0])
                    2'd0:    rdValue = {24'b0, rdData[31:24]};
                    2'd1:    rdValue = {24'b0, rdData[23:16]};
                    2'd2:    rdValue = {24'b0, rdData[15:8]};
                    default: rdValue = {24'b0, rdData[7:0]};
                endcase
            end
            SZ_HALF: rdValue = latAddr[1] ? {16'b0, rdData[15:0]} : {16'b0, rdData[31:16]};
            default: rdValue = rdData;
        endcase
    end

    // Preload owns the array only in IDLE; otherwise the latched request does.
    always_comb begin
        arrWrEn     = 4'h0;
        arrWrData   = ld_data;
        arrWordAddr = (state == IDLE) ? ld_addr : latAddr[ADDR_W-1:2];
        if (!clr) begin
            if ((state == IDLE) && ld_en && !mov) begin
                arrWrEn   = 4'hF;
                arrWrData = ld_data;
            end else if (commit && !latRw) begin
                arrWrEn   = laneEn;
                arrWrData = laneData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            mfc   <= 1'b0;
            err   <= 1'b0;
            dout  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mov) begin
                        latAddr <= addr;
                        latRw   <= rw;
                        latSz   <= word_sel;
                        latDin  <= din;
                        if (!isLegal(word_sel, addr[1:0])) begin
                            state <= DONE;
                            mfc   <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (latRw) begin
                            dout <= rdValue;
                        end
                        state <= DONE;
                        mfc   <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!mov) begin
                        state <= IDLE;
                        mfc   <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    mfc   <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
